// File: rtl/pipeline_scoreboard_pkg.sv
// Shared types and constants for the pipeline scoreboard and its users.
package pipeline_pkg;

  // Storage widths of a tracked write; large enough for any legal AW and STAGES (<= 7).
  localparam int unsigned SB_RD_W    = 16;
  localparam int unsigned SB_AVAIL_W = 3;

  // Forward select meaning "read the register file".
  localparam int unsigned FWD_REGFILE = 0;

  // Post-decode stage numbering.
  localparam int unsigned SB_EX  = 1;
  localparam int unsigned SB_MEM = 2;
  localparam int unsigned SB_WB  = 3;

  // First stage whose output carries the result, per instruction class.
  localparam int unsigned AVAIL_ALU  = 2;
  localparam int unsigned AVAIL_LOAD = 3;

  // One in-flight destination write.
  typedef struct packed {
    logic                  valid;
    logic [SB_RD_W-1:0]    rd;
    logic [SB_AVAIL_W-1:0] avail;
  } sb_entry_t;

  // Bound the availability stage to 1..stages.
  function automatic logic [SB_AVAIL_W-1:0] sb_clamp_avail(
    input logic [SB_AVAIL_W-1:0] avail,
    input int unsigned           stages
  );
    logic [SB_AVAIL_W-1:0] res;
    res = avail;
    if (avail == '0) begin
      res = SB_AVAIL_W'(1);
    end else if (32'(avail) > stages) begin
      res = SB_AVAIL_W'(stages);
    end
    return res;
  endfunction

endpackage

// File: rtl/pipeline_scoreboard_if.sv
// Decode-side bundle between the ID stage and the scoreboard.
interface pipeline_scoreboard_if #(
  parameter int unsigned STAGES  = 3,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned AW      = 5
);
  localparam int unsigned SW = $clog2(STAGES + 1);

  logic                  issue_valid;
  logic                  issue_we;
  logic [AW-1:0]         issue_rd;
  logic [SW-1:0]         issue_avail;
  logic [NUM_SRC-1:0]    src_used;
  logic [NUM_SRC*AW-1:0] src_addr;
  logic                  flush;
  logic                  stall;
  logic [NUM_SRC*SW-1:0] fwd_sel;

  // ID stage: supplies decode info, consumes hazard decisions.
  modport master (
    output issue_valid, issue_we, issue_rd, issue_avail, src_used, src_addr, flush,
    input  stall, fwd_sel
  );

  // Scoreboard: consumes decode info, drives hold/bubble and bypass selects.
  modport slave (
    input  issue_valid, issue_we, issue_rd, issue_avail, src_used, src_addr, flush,
    output stall, fwd_sel
  );
endinterface

// File: rtl/pipeline_scoreboard_sb_match.sv
// Combinational match of one source operand against the in-flight write array.
module sb_match
  import pipeline_pkg::*;
#(
  parameter int unsigned STAGES = 3,
  parameter int unsigned AW     = 5
) (
  input  logic                   used_i,
  input  logic [AW-1:0]          addr_i,
  input  sb_entry_t [STAGES-1:0] entries_i,
  output logic                   hit_o,
  output logic [$clog2(STAGES+1)-1:0] sel_o,
  output logic                   stall_o
);
  localparam int unsigned SW = $clog2(STAGES + 1);

  // Scan oldest to youngest so the youngest producer overrides older ones.
  always_comb begin
    hit_o   = 1'b0;
    sel_o   = SW'(FWD_REGFILE);
    stall_o = 1'b0;
    if (used_i && (addr_i != '0)) begin
      for (int unsigned s = STAGES; s >= 1; s--) begin
        if (entries_i[s-1].valid && (entries_i[s-1].rd == SB_RD_W'(addr_i))) begin
          hit_o = 1'b1;
          if (s >= 32'(entries_i[s-1].avail)) begin
            sel_o   = SW'(s);
            stall_o = 1'b0;
          end else begin
            sel_o   = SW'(FWD_REGFILE);
            stall_o = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_scoreboard.sv
// Hazard tracker and forwarding controller: tracks in-flight writes per post-ID stage,
// selects the youngest forwarding stage per source, or stalls ID until the result exists.
module pipeline_scoreboard
  import pipeline_pkg::*;
#(
  parameter int unsigned STAGES  = 3,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned AW      = 5,
  parameter int unsigned CW      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  pipeline_scoreboard_if.slave  sb_if,
  output logic [STAGES-1:0]     stage_valid,
  output logic [CW-1:0]         stall_count,
  output logic [CW-1:0]         fwd_count
);
  localparam int unsigned SW = $clog2(STAGES + 1);

  sb_entry_t [STAGES-1:0] entries_q, entries_d;
  logic [CW-1:0]          stall_count_q, stall_count_d;
  logic [CW-1:0]          fwd_count_q, fwd_count_d;

  logic [NUM_SRC-1:0]     src_hit_c;
  logic [NUM_SRC-1:0]     src_stall_c;
  logic [NUM_SRC*SW-1:0]  fwd_sel_c;
  logic                   stall_c;
  logic                   any_fwd_c;

  // One matcher per source operand.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    sb_match #(
      .STAGES (STAGES),
      .AW     (AW)
    ) u_match (
      .used_i    (sb_if.src_used[g]),
      .addr_i    (sb_if.src_addr[g*AW +: AW]),
      .entries_i (entries_q),
      .hit_o     (src_hit_c[g]),
      .sel_o     (fwd_sel_c[g*SW +: SW]),
      .stall_o   (src_stall_c[g])
    );
  end

  // Hold ID only for a live, unflushed instruction; a flush always wins.
  always_comb begin
    stall_c   = sb_if.issue_valid & ~sb_if.flush & (|src_stall_c);
    // A hit that does not stall always carries a non-zero stage select.
    any_fwd_c = |(src_hit_c & ~src_stall_c);
  end

  assign sb_if.stall   = stall_c;
  assign sb_if.fwd_sel = fwd_sel_c;

  // Shift tracked writes one stage older; stage 1 takes the accepted ID write or a bubble.
  always_comb begin
    entries_d = entries_q;
    for (int unsigned s = 1; s < STAGES; s++) begin
      entries_d[s] = entries_q[s-1];
    end
    entries_d[0].valid = sb_if.issue_valid & sb_if.issue_we & (sb_if.issue_rd != '0)
                         & ~stall_c & ~sb_if.flush;
    entries_d[0].rd    = SB_RD_W'(sb_if.issue_rd);
    entries_d[0].avail = sb_clamp_avail(SB_AVAIL_W'(sb_if.issue_avail), STAGES);
  end

  // Saturating performance counters.
  always_comb begin
    stall_count_d = stall_count_q;
    fwd_count_d   = fwd_count_q;
    if (stall_c && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CW'(1);
    end
    if (!stall_c && any_fwd_c && (fwd_count_q != '1)) begin
      fwd_count_d = fwd_count_q + CW'(1);
    end
  end

  // State registers; reset empties the pipeline view immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entries_q     <= '0;
      stall_count_q <= '0;
      fwd_count_q   <= '0;
    end else begin
      entries_q     <= entries_d;
      stall_count_q <= stall_count_d;
      fwd_count_q   <= fwd_count_d;
    end
  end

  // Debug view of occupied stages.
  always_comb begin
    stage_valid = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      stage_valid[s] = entries_q[s].valid;
    end
  end

  assign stall_count = stall_count_q;
  assign fwd_count   = fwd_count_q;

endmodule

// File: doc/pipeline_scoreboard.md
Name: pipeline_scoreboard

Overview:
- Parametrised hazard tracker and forwarding controller for the pipelined core. Replaces the stall-on-any-dependence check with per-stage result tracking.
- Keeps a shift register of in-flight destination writes, one entry per post-decode stage.
- For each decode-stage source operand, picks the youngest producing stage to forward from, or asserts stall when that result is not yet available.
- Sits beside the datapath: consumes ID-stage decode info, drives the ID/EX hold-and-bubble control and the operand bypass muxes.

Parameters:
- STAGES, 3, number of tracked post-ID stages (1=EX, 2=MEM, 3=WB); legal range 1..7.
- NUM_SRC, 2, number of source operands checked per issuing instruction.
- AW, 5, register address width.
- SW, $clog2(STAGES+1), width of stage index / forward select (derived, not overridable).
- CW, 32, width of performance counters.

Ports:
- clock  in  1  core clock.
- reset  in  1  reset.
- issue_valid  in  1  ID holds a real instruction.
- issue_we  in  1  ID instruction writes rd.
- issue_rd  in  AW  ID destination register.
- issue_avail  in  SW  first stage whose output carries the result (ALU=2, load=3).
- src_used  in  NUM_SRC  per-source "operand read from regfile" flag.
- src_addr  in  NUM_SRC*AW  per-source register address, source i at [i*AW +: AW].
- flush  in  1  kill the ID instruction (branch resolved in EX); a bubble enters stage 1.
- stall  out  1  hold PC and ID, bubble into stage 1.
- fwd_sel  out  NUM_SRC*SW  per source: 0 = regfile, s = forward from stage s output.
- stage_valid  out  STAGES  debug: entry s-1 holds a tracked write.
- stall_count  out  CW  cycles with stall=1.
- fwd_count  out  CW  cycles with any fwd_sel≠0 and stall=0.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock.
- State: entries e[1..STAGES], each {valid, rd, avail}.
- On reset: all entries invalid and both counters 0. As a result stall=0, fwd_sel=0 and stage_valid=0 immediately after reset.
- Advance, every cycle, with no global hold:
  - e[s+1] <= e[s] for s = 1..STAGES-1; e[STAGES] retires.
  - e[1] <= {issue_valid & issue_we & (issue_rd≠0) & ~stall & ~flush, issue_rd, clamp(issue_avail)}.
  - clamp: 0 becomes 1; values above STAGES become STAGES.
- Match, combinational per source i:
  - If src_used[i]=0 or src_addr[i]=0: fwd_sel[i]=0, no stall contribution.
  - Otherwise find the smallest s with e[s].valid and e[s].rd == src_addr[i], giving the youngest producer.
  - No match: fwd_sel[i]=0.
  - Match with s >= e[s].avail: fwd_sel[i]=s.
  - Match with s < e[s].avail: source stalls and fwd_sel[i]=0.
- Output combination:
  - stall = issue_valid & ~flush & OR(source stalls).
  - A flush wins over stall in the same cycle: stall=0, and the bubble enters stage 1.
  - The regfile is not write-through, so a write retiring from stage STAGES is reached only by forwarding from stage STAGES. It is never forwarded from regfile in the same cycle.
- Latency: decisions are zero-cycle combinational from current state. Stall resolves automatically as the producer advances; no explicit release is needed.
- Counters increment by 1 per qualifying cycle and saturate at all-ones (no wrap).
- Asserting reset mid-stall clears all entries asynchronously; stall drops in the same cycle.
- Both sources matching the same rd receive identical fwd_sel.
- Multiple stages holding the same rd: the youngest wins; older entries are ignored.
- STAGES=1: only avail=1 is forwardable; any match with avail>1 after clamping cannot occur.

Decomposition:
- Shared package pipeline_pkg holds:
  - typedef sb_entry_t {valid, rd, avail}.
  - FWD_REGFILE = 0.
  - Stage constants SB_EX=1, SB_MEM=2, SB_WB=3.
  - AVAIL_ALU=2, AVAIL_LOAD=3.
- Sub-module sb_match: one source against the entry array → {hit, sel, stall}. The block instantiates it NUM_SRC times via generate.

Test Plan:
- ALU dependence: issue addi x5 (avail=2), then next cycle add x6,x5,x1 → cycle 1: stall=1, fwd_sel[0]=0. Cycle 2: stall=0, fwd_sel[0]=2 (MEM).
- Load-use: lw x7 (avail=3), then immediately sub x8,x7,x7 → stall=1 for 2 cycles, then fwd_sel[0]=fwd_sel[1]=3. stall_count=2.
- Youngest wins: addi x3 issued twice back-to-back, then or x9,x3,x0 one bubble later → matches both stage 2 and stage 3; fwd_sel[0]=2.
- x0 and unused sources: addi x0 followed by add x4,x0,x0, and a lui with src_used=00 behind x5 writer → stall=0, fwd_sel=0, stage_valid shows no x0 entry.
- Flush during stall: lw x7, then use of x7 with flush=1 in the stall cycle → stall=0, stage 1 gets a bubble. Next cycle with issue_valid=0, no stall.
- Async reset mid-stall: assert reset while stall=1 → stall, fwd_sel, stage_valid and counters all 0 before the next clock edge. Counter saturation forced with CW=4: 20 stall cycles → stall_count=15.
